// File: rtl/e_sync_bank_if.sv
// Channel bundle for e_sync_bank: asynchronous inputs and clears from the requester,
// synchronized levels, pulses and sticky status back from the bank.
interface e_sync_bank_if #(
  parameter int unsigned NCH = 8
);
  logic [NCH-1:0] async_in;
  logic [NCH-1:0] ev_clr;
  logic [NCH-1:0] sync_out;
  logic [NCH-1:0] pulse_out;
  logic [NCH-1:0] ev_sticky;
  logic [NCH-1:0] ev_overrun;

  modport master (
    output async_in, ev_clr,
    input  sync_out, pulse_out, ev_sticky, ev_overrun
  );

  modport slave (
    input  async_in, ev_clr,
    output sync_out, pulse_out, ev_sticky, ev_overrun
  );
endinterface

// File: rtl/e_sync_bank.sv
// Bank of NCH multi-flop synchronizers into sys_clk with level/toggle/rise/fall event
// detection and W1C sticky/overrun flags. Define E_SYNC_FILTER_EN for the glitch filter.
module e_sync_bank #(
  parameter int unsigned       NCH      = 8,
  parameter int unsigned       STAGES   = 2,
  parameter logic [2*NCH-1:0]  MODE     = {2*NCH{1'b0}},
  parameter int unsigned       FILT_LEN = 3
) (
  input  logic           sys_clk,
  input  logic           rst,
  e_sync_bank_if.slave   bus
);

  localparam logic [1:0] MODE_LEVEL  = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_RISE   = 2'b10;
  localparam logic [1:0] MODE_FALL   = 2'b11;

  if (NCH < 1 || NCH > 32 || STAGES < 2 || FILT_LEN < 1) begin : g_cfg_err
    $error("e_sync_bank: illegal NCH/STAGES/FILT_LEN");
  end

  logic [NCH-1:0] sync_vec;
  logic [NCH-1:0] pulse_vec_c;
  logic [NCH-1:0] sticky_vec;
  logic [NCH-1:0] ovr_vec;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [1:0] CH_MODE = MODE[2*i +: 2];

    logic [STAGES-1:0] s_q, s_d;
    logic              d_q, d_d;
    logic              sticky_q, sticky_d;
    logic              ovr_q, ovr_d;
    logic              lvl_c;
    logic              pulse_c;

    // s_q[0] is the first capture flop, s_q[STAGES-1] the settled level
    always_comb begin
      s_d = {s_q[STAGES-2:0], bus.async_in[i]};
    end

`ifdef E_SYNC_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             f_q, f_d;

    // Accept a new level only after it has differed from f for FILT_LEN cycles
    always_comb begin
      f_d   = f_q;
      cnt_d = '0;
      if (s_q[STAGES-1] != f_q) begin
        if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
          f_d = s_q[STAGES-1];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge sys_clk) begin
      if (rst) begin
        cnt_q <= '0;
        f_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        f_q   <= f_d;
      end
    end

    assign lvl_c = f_q;
`else
    assign lvl_c = s_q[STAGES-1];
`endif

    always_comb begin
      pulse_c = 1'b0;
      case (CH_MODE)
        MODE_LEVEL:  pulse_c = 1'b0;
        MODE_TOGGLE: pulse_c = lvl_c ^ d_q;
        MODE_RISE:   pulse_c = lvl_c & ~d_q;
        MODE_FALL:   pulse_c = ~lvl_c & d_q;
        default:     pulse_c = 1'b0;
      endcase
    end

    // Set beats clear so an event coinciding with a W1C is never dropped
    always_comb begin
      d_d      = lvl_c;
      sticky_d = sticky_q;
      ovr_d    = ovr_q;
      if (pulse_c) begin
        sticky_d = 1'b1;
      end else if (bus.ev_clr[i]) begin
        sticky_d = 1'b0;
      end
      if (pulse_c && sticky_q && !bus.ev_clr[i]) begin
        ovr_d = 1'b1;
      end else if (bus.ev_clr[i]) begin
        ovr_d = 1'b0;
      end
    end

    always_ff @(posedge sys_clk) begin
      if (rst) begin
        s_q      <= '0;
        d_q      <= 1'b0;
        sticky_q <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        s_q      <= s_d;
        d_q      <= d_d;
        sticky_q <= sticky_d;
        ovr_q    <= ovr_d;
      end
    end

    assign sync_vec[i]    = lvl_c;
    assign pulse_vec_c[i] = pulse_c;
    assign sticky_vec[i]  = sticky_q;
    assign ovr_vec[i]     = ovr_q;
  end

  assign bus.sync_out   = sync_vec;
  assign bus.pulse_out  = pulse_vec_c;
  assign bus.ev_sticky  = sticky_vec;
  assign bus.ev_overrun = ovr_vec;

endmodule

// File: tb/tb_e_sync_bank.sv
// Randomized scoreboard bench for e_sync_bank: a history-based reference model predicts
// every output vector per cycle; a monitor compares after each sys_clk edge.
module tb_e_sync_bank;

  localparam int unsigned      NCH      = 8;
  localparam int unsigned      STAGES   = 2;
  localparam int unsigned      FILT_LEN = 3;
  localparam logic [2*NCH-1:0] MODE     = 16'hE4E4;
  localparam int unsigned      NCYC     = 4000;

  typedef struct packed {
    logic [NCH-1:0] sync;
    logic [NCH-1:0] pulse;
    logic [NCH-1:0] sticky;
    logic [NCH-1:0] ovr;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   started = 1'b0;

  exp_t           exp_q[$];
  logic [NCH-1:0] hist[$];
  logic [NCH-1:0] win[$];
  logic [NCH-1:0] m_lvl, m_prev, m_f, m_sticky, m_ovr;

  e_sync_bank_if #(.NCH(NCH)) bus ();

  e_sync_bank #(
    .NCH(NCH), .STAGES(STAGES), .MODE(MODE), .FILT_LEN(FILT_LEN)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Event seen by a channel when its settled level moves from prev to now
  function automatic logic [NCH-1:0] events(input logic [NCH-1:0] now, input logic [NCH-1:0] prev);
    logic [NCH-1:0]   ev;
    logic [2*NCH-1:0] mv;
    bit               changed;
    mv = MODE;
    ev = '0;
    for (int i = 0; i < NCH; i++) begin
      changed = (now[i] != prev[i]);
      case (mv[2*i +: 2])
        2'b01:   ev[i] = changed;
        2'b10:   ev[i] = changed && now[i];
        2'b11:   ev[i] = changed && !now[i];
        default: ev[i] = 1'b0;
      endcase
    end
    return ev;
  endfunction

  task automatic model_edge(input logic r, input logic [NCH-1:0] in, input logic [NCH-1:0] clr);
    logic [NCH-1:0] ev, settled, all1, all0;
    exp_t e;
    if (r) begin
      hist.delete();
      win.delete();
      for (int k = 0; k < int'(STAGES); k++) hist.push_back('0);
      m_lvl = '0; m_prev = '0; m_f = '0; m_sticky = '0; m_ovr = '0;
    end else begin
      ev       = events(m_lvl, m_prev);
      m_ovr    = (ev & m_sticky & ~clr) | (m_ovr & ~clr);
      m_sticky = ev | (m_sticky & ~clr);
      settled  = hist[$-(STAGES-1)];
      hist.push_back(in);
      if (hist.size() > 64) void'(hist.pop_front());
      m_prev = m_lvl;
`ifdef E_SYNC_FILTER_EN
      win.push_back(settled);
      if (win.size() > FILT_LEN) void'(win.pop_front());
      if (win.size() == FILT_LEN) begin
        all1 = '1;
        all0 = '1;
        foreach (win[k]) begin
          all1 &= win[k];
          all0 &= ~win[k];
        end
        m_f = (m_f & ~all0) | all1;
      end
      m_lvl = m_f;
`else
      all1  = '0;
      all0  = settled;
      m_lvl = hist[$-(STAGES-1)];
`endif
    end
    e.sync   = m_lvl;
    e.pulse  = events(m_lvl, m_prev);
    e.sticky = m_sticky;
    e.ovr    = m_ovr;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Monitor: one expected vector per edge once stimulus has started
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (started) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard cycle %0d: got empty queue expected an entry", cyc);
        end else begin
          e = exp_q.pop_front();
          check("sync_out",   bus.sync_out,   e.sync);
          check("pulse_out",  bus.pulse_out,  e.pulse);
          check("ev_sticky",  bus.ev_sticky,  e.sticky);
          check("ev_overrun", bus.ev_overrun, e.ovr);
        end
        cyc++;
      end
    end
  end

  // Driver: random levels with random hold times, random W1C, occasional resets
  initial begin
    int             hold[NCH];
    logic [NCH-1:0] lvl, clr, cur_ev;
    logic           r;
    rst          = 1'b1;
    bus.async_in = '0;
    bus.ev_clr   = '0;
    lvl          = '0;
    foreach (hold[i]) hold[i] = 0;
    for (int c = 0; c < int'(NCYC); c++) begin
      @(negedge sys_clk);
      r = (c < 3) || (c == 2000) || (c > 20 && $urandom_range(0, 499) == 0);
      for (int i = 0; i < NCH; i++) begin
        if (hold[i] == 0) begin
          lvl[i]  = $urandom_range(0, 1) == 1;
          hold[i] = (c < 200) ? $urandom_range(2, 9) : $urandom_range(1, 9);
        end else begin
          hold[i]--;
        end
      end
      if (c >= 1990 && c <= 2012) lvl = '1;
      clr = '0;
      for (int i = 0; i < NCH; i++) clr[i] = ($urandom_range(0, 7) == 0);
      // Deliberately collide W1C with a live event on a flagged channel
      if (c >= 1000 && c < 1600) begin
        cur_ev = events(m_lvl, m_prev);
        if ($urandom_range(0, 1) == 1) clr = clr | (cur_ev & m_sticky);
      end
      rst          = r;
      bus.async_in = lvl;
      bus.ev_clr   = clr;
      model_edge(r, lvl, clr);
      started = 1'b1;
    end
    @(posedge sys_clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
